fpu_issue_arbiter: RTL

//  Shares one pipelined single-precision FPU core between NREQ requesters.

---
 rtl/fpu_issue_arbiter_pkg.sv | 35 +++
 rtl/fpu_issue_arbiter_rr_arbiter.sv | 37 +++
 rtl/fpu_issue_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fpu_issue_arbiter_pkg.sv
// Shared types and constants for the FPU issue arbiter: opcode enum, flag layout,
// and the canonical result substituted for unsupported opcodes.
package fpu_pkg;

  localparam int FLAG_W = 8;
  localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;
  localparam logic [FLAG_W-1:0] BAD_OP_FLAGS = 8'h02;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    MUL  = 3'd2,
    DIV  = 3'd3,
    I2F  = 3'd4,
    F2I  = 3'd5,
    RSV6 = 3'd6,
    RSV7 = 3'd7
  } fpu_op_e;

  typedef struct packed {
    logic div_by_zero;
    logic zero;
    logic underflow;
    logic overflow;
    logic ine;
    logic qnan;
    logic snan;
    logic inf;
  } fpu_flags_t;

  function automatic logic is_bad_op(input logic [2:0] op);
    return (fpu_op_e'(op) == RSV6) || (fpu_op_e'(op) == RSV7);
  endfunction

endpackage

// File: rtl/fpu_issue_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping, reported both as a one-hot grant and as an encoded index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDW = $clog2(N);

  logic [IDW:0]   sum;
  logic [IDW-1:0] pos;
  logic           found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      // Modulo by subtraction keeps the search correct for non-power-of-two N.
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
      pos = sum[IDW-1:0];
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Shares one pipelined FPU between NREQ clients; a shadow tag pipe returns each
// result with its requester ID. Optional STICKY_FLAGS_EN adds per-requester sticky flags.
module fpu_issue_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*3-1:0]          req_op,
  input  logic [NREQ*2-1:0]          req_rmode,
  input  logic [NREQ*32-1:0]         req_opa,
  input  logic [NREQ*32-1:0]         req_opb,
  output logic [2:0]                 fpu_op,
  output logic [1:0]                 fpu_rmode,
  output logic [31:0]                fpu_opa,
  output logic [31:0]                fpu_opb,
  input  logic [31:0]                fpu_out,
  input  logic [FLAG_W-1:0]          fpu_flags,
  output logic                       rsp_valid,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [31:0]                rsp_out,
`ifdef STICKY_FLAGS_EN
  input  logic                       flag_clr,
  output logic [NREQ*FLAG_W-1:0]     sticky_flags,
`endif
  output logic [FLAG_W-1:0]          rsp_flags
);

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  rr_ptr;
  logic            accept;
  logic [2:0]      sel_op;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign req_ready = rst ? '0 : grant;
  assign accept    = |req_ready;
  assign sel_op    = req_op[gnt_idx*3 +: 3];

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  // ---- p0: issue register driving the FPU operand bus ----
  logic [2:0]  op_p0;
  logic [1:0]  rmode_p0;
  logic [31:0] opa_p0;
  logic [31:0] opb_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_p0    <= '0;
      rmode_p0 <= '0;
      opa_p0   <= '0;
      opb_p0   <= '0;
    end else if (accept) begin
      op_p0    <= sel_op;
      rmode_p0 <= req_rmode[gnt_idx*2 +: 2];
      opa_p0   <= req_opa[gnt_idx*32 +: 32];
      opb_p0   <= req_opb[gnt_idx*32 +: 32];
    end
  end

  assign fpu_op    = op_p0;
  assign fpu_rmode = rmode_p0;
  assign fpu_opa   = opa_p0;
  assign fpu_opb   = opb_p0;

  // ---- p0..pLATENCY: tag shadow pipe, aligned with the FPU result ----
  logic [LATENCY:0] vld_p;
  logic [LATENCY:0] bad_p;
  logic [IDW-1:0]   id_p [LATENCY+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      bad_p <= '0;
      for (int i = 0; i <= LATENCY; i++) id_p[i] <= '0;
    end else begin
      vld_p <= {vld_p[LATENCY-1:0], accept};
      bad_p <= {bad_p[LATENCY-1:0], accept & is_bad_op(sel_op)};
      id_p[0] <= gnt_idx;
      for (int i = 1; i <= LATENCY; i++) id_p[i] <= id_p[i-1];
    end
  end

  // ---- response: tag pipe output merged with the FPU result ----
  fpu_flags_t flags_in;
  assign flags_in  = fpu_flags;
  // Gating with rst drops a tag that is still visible during the reset cycle.
  assign rsp_valid = vld_p[LATENCY] & ~rst;

  always_comb begin
    rsp_id    = '0;
    rsp_out   = '0;
    rsp_flags = '0;
    if (rsp_valid) begin
      rsp_id    = id_p[LATENCY];
      rsp_out   = bad_p[LATENCY] ? CANON_QNAN : fpu_out;
      rsp_flags = bad_p[LATENCY] ? BAD_OP_FLAGS : flags_in;
    end
  end

`ifdef STICKY_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst || flag_clr)
      sticky_flags <= '0;
    else if (rsp_valid)
      sticky_flags[rsp_id*FLAG_W +: FLAG_W] <= sticky_flags[rsp_id*FLAG_W +: FLAG_W] | rsp_flags;
  end
`endif

endmodule
